// File: rtl/eh2_lsu_amo_wbuf.sv
// In-order write buffer for committed AMO/SC results awaiting the DCCM write port,
// with younger-load hazard detection. Define LSU_AMO_WBUF_FWD_EN to forward instead of stall.
module eh2_lsu_amo_wbuf #(
  parameter int DEPTH       = 2,
  parameter int DCCM_ADDR_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   amo_valid_dc4,
  input  logic                   amo_flush_dc4,
  input  logic                   amo_tid_dc4,
  input  logic [DCCM_ADDR_W-1:0] amo_addr_dc4,
  input  logic [31:0]            amo_data_dc4,
  output logic                   wr_req,
  output logic [DCCM_ADDR_W-1:0] wr_addr,
  output logic [31:0]            wr_data,
  output logic                   wr_tid,
  input  logic                   wr_ack,
  input  logic                   ld_chk_valid,
  input  logic [DCCM_ADDR_W-1:0] ld_chk_addr,
  output logic                   ld_hit_stall,
  output logic                   ld_fwd_valid,
  output logic [31:0]            ld_fwd_data,
  output logic                   wbuf_full,
  output logic                   wbuf_empty,
  output logic                   wbuf_ovf_err
);
  // state    | meaning
  // S_EMPTY  | no pending entries, wr_req low
  // S_ACTIVE | 1..DEPTH-1 entries pending
  // S_FULL   | DEPTH entries pending, new AMOs must be blocked
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {S_EMPTY, S_ACTIVE, S_FULL} state_t;

  state_t                 state, state_nxt;
  logic [CW-1:0]          count;
  logic [PW-1:0]          rd_ptr, wr_ptr;
  logic [DEPTH-1:0]       valid_q;
  logic [DEPTH-1:0]       tid_q;
  logic [DCCM_ADDR_W-1:0] addr_q [DEPTH];
  logic [31:0]            data_q [DEPTH];
  logic                   push, pop, ovf_set, hit;
  logic                   unused_ld_lo;

  assign pop     = wr_req & wr_ack;
  assign push    = amo_valid_dc4 & ~amo_flush_dc4 & (~wbuf_full | pop);
  assign ovf_set = amo_valid_dc4 & ~amo_flush_dc4 & wbuf_full & ~pop;
  assign unused_ld_lo = ^ld_chk_addr[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_EMPTY;
      count        <= '0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      wbuf_ovf_err <= 1'b0;
    end else begin
      state <= state_nxt;
      count <= count + CW'(push) - CW'(pop);
      if (pop)     rd_ptr       <= rd_ptr + PW'(1);
      if (push)    wr_ptr       <= wr_ptr + PW'(1);
      if (ovf_set) wbuf_ovf_err <= 1'b1;
    end
  end

  // Pop clears before push sets so a full-buffer push+pop on the same slot stays valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      tid_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      if (pop) valid_q[rd_ptr] <= 1'b0;
      if (push) begin
        valid_q[wr_ptr] <= 1'b1;
        tid_q[wr_ptr]   <= amo_tid_dc4;
        addr_q[wr_ptr]  <= amo_addr_dc4;
        data_q[wr_ptr]  <= amo_data_dc4;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_EMPTY:  if (push) state_nxt = S_ACTIVE;
      S_ACTIVE: begin
        if (push && !pop && count == CW'(DEPTH - 1)) state_nxt = S_FULL;
        else if (pop && !push && count == CW'(1))    state_nxt = S_EMPTY;
      end
      S_FULL:   if (pop && !push) state_nxt = S_ACTIVE;
      default:  state_nxt = S_EMPTY;
    endcase
  end

  always_comb begin
    wr_req     = (state != S_EMPTY);
    wbuf_full  = (state == S_FULL);
    wbuf_empty = (state == S_EMPTY);
    wr_addr    = addr_q[rd_ptr];
    wr_data    = data_q[rd_ptr];
    wr_tid     = tid_q[rd_ptr];
  end

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if (valid_q[i] && addr_q[i][DCCM_ADDR_W-1:2] == ld_chk_addr[DCCM_ADDR_W-1:2])
        hit = ld_chk_valid;
  end

`ifdef LSU_AMO_WBUF_FWD_EN
  // Walk oldest to youngest from the head so the last match is the youngest write.
  always_comb begin
    ld_fwd_data = '0;
    for (int k = 0; k < DEPTH; k++)
      if (valid_q[rd_ptr + PW'(k)] &&
          addr_q[rd_ptr + PW'(k)][DCCM_ADDR_W-1:2] == ld_chk_addr[DCCM_ADDR_W-1:2])
        ld_fwd_data = data_q[rd_ptr + PW'(k)];
    ld_fwd_valid = hit;
    ld_hit_stall = 1'b0;
  end
`else
  always_comb begin
    ld_fwd_data  = '0;
    ld_fwd_valid = 1'b0;
    ld_hit_stall = hit;
  end
`endif
endmodule

// File: tb/tb_eh2_lsu_amo_wbuf.sv
// Bench for eh2_lsu_amo_wbuf: directed scenarios plus random traffic against a queue model.
module tb_eh2_lsu_amo_wbuf;
  localparam int DEPTH = 2;
  localparam int AW    = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          amo_valid_dc4, amo_flush_dc4, amo_tid_dc4;
  logic [AW-1:0] amo_addr_dc4;
  logic [31:0]   amo_data_dc4;
  logic          wr_req, wr_tid, wr_ack;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic          ld_chk_valid;
  logic [AW-1:0] ld_chk_addr;
  logic          ld_hit_stall, ld_fwd_valid;
  logic [31:0]   ld_fwd_data;
  logic          wbuf_full, wbuf_empty, wbuf_ovf_err;

  eh2_lsu_amo_wbuf #(.DEPTH(DEPTH), .DCCM_ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .amo_valid_dc4(amo_valid_dc4), .amo_flush_dc4(amo_flush_dc4),
    .amo_tid_dc4(amo_tid_dc4), .amo_addr_dc4(amo_addr_dc4), .amo_data_dc4(amo_data_dc4),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_tid(wr_tid), .wr_ack(wr_ack),
    .ld_chk_valid(ld_chk_valid), .ld_chk_addr(ld_chk_addr),
    .ld_hit_stall(ld_hit_stall), .ld_fwd_valid(ld_fwd_valid), .ld_fwd_data(ld_fwd_data),
    .wbuf_full(wbuf_full), .wbuf_empty(wbuf_empty), .wbuf_ovf_err(wbuf_ovf_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          tid;
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } ent_t;

  ent_t q[$];
  bit   m_ovf;
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    bit          hit = 1'b0;
    logic [31:0] fd  = '0;
    chk("wr_req", 32'(wr_req), 32'(q.size() != 0));
    if (q.size() != 0) begin
      chk("wr_addr", 32'(wr_addr), 32'(q[0].addr));
      chk("wr_data", wr_data, q[0].data);
      chk("wr_tid", 32'(wr_tid), 32'(q[0].tid));
    end
    chk("wbuf_full", 32'(wbuf_full), 32'(q.size() == DEPTH));
    chk("wbuf_empty", 32'(wbuf_empty), 32'(q.size() == 0));
    chk("wbuf_ovf_err", 32'(wbuf_ovf_err), 32'(m_ovf));
    if (ld_chk_valid === 1'b1)
      foreach (q[i])
        if (q[i].addr[AW-1:2] == ld_chk_addr[AW-1:2]) begin
          hit = 1'b1;
          fd  = q[i].data;
        end
`ifdef LSU_AMO_WBUF_FWD_EN
    chk("ld_fwd_valid", 32'(ld_fwd_valid), 32'(hit));
    chk("ld_hit_stall", 32'(ld_hit_stall), 32'(0));
    if (hit) chk("ld_fwd_data", ld_fwd_data, fd);
`else
    chk("ld_hit_stall", 32'(ld_hit_stall), 32'(hit));
    chk("ld_fwd_valid", 32'(ld_fwd_valid), 32'(0));
    chk("ld_fwd_data", ld_fwd_data, 32'(fd & 32'h0));
`endif
  endtask

  // Drive one cycle from a negedge, check, advance the model at posedge, return at negedge.
  task automatic cycle(input bit v, input bit f, input bit t, input logic [AW-1:0] a,
                       input logic [31:0] d, input bit ack, input bit ldv,
                       input logic [AW-1:0] la);
    bit   do_pop, do_push;
    ent_t e;
    amo_valid_dc4 = v; amo_flush_dc4 = f; amo_tid_dc4 = t;
    amo_addr_dc4 = a;  amo_data_dc4 = d;  wr_ack = ack;
    ld_chk_valid = ldv; ld_chk_addr = la;
    #1;
    check_outputs();
    do_pop  = (q.size() != 0) && ack;
    do_push = v && !f && ((q.size() < DEPTH) || do_pop);
    if (v && !f && q.size() == DEPTH && !do_pop) m_ovf = 1'b1;
    @(posedge clk);
    if (do_pop) void'(q.pop_front());
    if (do_push) begin
      e.tid = t; e.addr = a; e.data = d;
      q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic idle(input bit ack);
    cycle(0, 0, 0, '0, '0, ack, 0, '0);
  endtask

  task automatic do_reset();
    amo_valid_dc4 = 0; amo_flush_dc4 = 0; wr_ack = 0; ld_chk_valid = 0;
    rst = 1'b1;
    q.delete();
    m_ovf = 1'b0;
    #1;
    check_outputs();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    amo_valid_dc4 = 0; amo_flush_dc4 = 0; amo_tid_dc4 = 0;
    amo_addr_dc4 = '0; amo_data_dc4 = '0; wr_ack = 0;
    ld_chk_valid = 0; ld_chk_addr = '0;
    m_ovf = 1'b0;
    repeat (2) @(negedge clk);
    check_outputs();
    rst = 1'b0;
    @(negedge clk);

    // single push, acked on the first request cycle
    cycle(1, 0, 1, 16'h0040, 32'hDEAD_BEEF, 0, 0, '0);
    idle(1);
    idle(0);

    // flushed AMO is never captured
    cycle(1, 1, 0, 16'h0050, 32'h1234_5678, 0, 0, '0);
    idle(0);

    // fill, then overflow
    cycle(1, 0, 0, 16'h0004, 32'h0000_0011, 0, 0, '0);
    cycle(1, 0, 1, 16'h0008, 32'h0000_0022, 0, 0, '0);
    cycle(1, 0, 0, 16'h0010, 32'h0000_00FF, 0, 0, '0);
    idle(0);

    // push while full with same-cycle ack
    cycle(1, 0, 0, 16'h000C, 32'h0000_0033, 1, 0, '0);
    idle(0);

    // reset with two entries pending and overflow latched
    do_reset();
    idle(0);

    // same-word entries, load probes
    cycle(1, 0, 0, 16'h0040, 32'h0000_0011, 0, 0, '0);
    cycle(1, 0, 0, 16'h0040, 32'h0000_0022, 0, 1, 16'h0042);
    idle(0);
    cycle(0, 0, 0, '0, '0, 0, 1, 16'h0042);
    cycle(0, 0, 0, '0, '0, 0, 1, 16'h0044);
    cycle(0, 0, 0, '0, '0, 1, 1, 16'h0040);
    cycle(0, 0, 0, '0, '0, 1, 1, 16'h0043);
    idle(0);

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        cycle($urandom_range(0, 99) < 60, $urandom_range(0, 9) == 0, 1'($urandom),
              16'h0040 + 16'($urandom_range(0, 3) * 4), $urandom,
              $urandom_range(0, 99) < 45, 1'($urandom),
              16'h0040 + 16'($urandom_range(0, 15)));
      end
    end

    repeat (DEPTH + 1) idle(1);
    idle(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
